// File: rtl/proc_datapath_param_pkg.sv
// Shared types for the parameterised multi-cycle datapath: opcodes, FSM states,
// bus source selects and the instruction-field width helper.
package proc_pkg;

    typedef enum logic [2:0] {
        OP_MV   = 3'd0,
        OP_MVI  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_XOR  = 3'd5,
        OP_MVNZ = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T1   = 2'd1,
        ST_T2   = 2'd2,
        ST_T3   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_RX   = 3'd1,
        SEL_RY   = 3'd2,
        SEL_DIN  = 3'd3,
        SEL_G    = 3'd4
    } bus_sel_e;

    // Opcode plus two register indices, taken from the top of DIN.
    function automatic int iw(input int rw);
        return 3 + 2 * rw;
    endfunction

endpackage

// File: rtl/proc_datapath_param_if.sv
// Control, data-in and observation signals of the datapath as one bundle.
interface proc_datapath_param_if #(
    parameter int WIDTH    = 9,
    parameter int NUM_REGS = 8
);
    logic                      run;
    logic [WIDTH-1:0]          DIN;
    logic                      Done;
    logic                      IRin;
    logic                      busy;
    logic                      illegal;
    logic                      Z;
    logic                      C;
    logic [WIDTH-1:0]          BUS;
    logic [WIDTH-1:0]          A;
    logic [WIDTH-1:0]          G;
    logic [NUM_REGS*WIDTH-1:0] R_flat;

    modport master (
        output run, DIN,
        input  Done, IRin, busy, illegal, Z, C, BUS, A, G, R_flat
    );

    modport slave (
        input  run, DIN,
        output Done, IRin, busy, illegal, Z, C, BUS, A, G, R_flat
    );
endinterface

// File: rtl/proc_datapath_param_alu.sv
// Combinational ALU; the extra top bit of the internal sum is the carry out.
module proc_alu
    import proc_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
);
    logic [WIDTH:0] ext;

    always_comb begin
        ext = '0;
        case (op)
            OP_ADD:  ext = {1'b0, a} + {1'b0, b};
            // Two's-complement subtract: carry set means no borrow.
            OP_SUB:  ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            OP_AND:  ext = {1'b0, a & b};
            OP_XOR:  ext = {1'b0, a ^ b};
            default: ext = '0;
        endcase
    end

    assign result = ext[WIDTH-1:0];
    assign carry  = ext[WIDTH];
endmodule

// File: rtl/proc_datapath_param.sv
// Multi-cycle datapath: register file, A/G registers, shared bus and control FSM.
module proc_datapath_param
    import proc_pkg::*;
#(
    parameter int WIDTH    = 9,
    parameter int NUM_REGS = 8
) (
    input logic                  clk,
    input logic                  rst,
    proc_datapath_param_if.slave io
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int IW = iw(RW);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_T1   = ST_T1;
    localparam logic [1:0] S_T2   = ST_T2;
    localparam logic [1:0] S_T3   = ST_T3;

    logic [1:0]                     state, state_nxt;
    logic [IW-1:0]                  ir;
    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]               a, g, bus, alu_res;
    logic                           z, c, alu_c;
    op_e                            op;
    logic [RW-1:0]                  rx, ry;
    bus_sel_e                       sel;
    logic                           rx_wr, a_wr, g_wr, done, bad_op, ir_load;

    assign op = op_e'(ir[IW-1 -: 3]);
    assign rx = ir[2*RW-1 -: RW];
    assign ry = ir[RW-1:0];

    always_comb begin
        sel       = SEL_NONE;
        rx_wr     = 1'b0;
        a_wr      = 1'b0;
        g_wr      = 1'b0;
        done      = 1'b0;
        bad_op    = 1'b0;
        ir_load   = 1'b0;
        state_nxt = state;
        case (state)
            S_IDLE: begin
                ir_load = io.run & rst;
                if (io.run) state_nxt = S_T1;
            end
            S_T1: begin
                state_nxt = S_IDLE;
                done      = 1'b1;
                case (op)
                    OP_MV:   begin sel = SEL_RY;  rx_wr = 1'b1; end
                    OP_MVI:  begin sel = SEL_DIN; rx_wr = 1'b1; end
                    OP_MVNZ: begin sel = SEL_RY;  rx_wr = ~z;   end
                    OP_RSVD: bad_op = 1'b1;
                    default: begin
                        sel       = SEL_RX;
                        a_wr      = 1'b1;
                        done      = 1'b0;
                        state_nxt = S_T2;
                    end
                endcase
            end
            S_T2: begin
                sel       = SEL_RY;
                g_wr      = 1'b1;
                state_nxt = S_T3;
            end
            default: begin
                sel       = SEL_G;
                rx_wr     = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (sel)
            SEL_RX:  bus = regs[rx];
            SEL_RY:  bus = regs[ry];
            SEL_DIN: bus = io.DIN;
            SEL_G:   bus = g;
            default: bus = '0;
        endcase
    end

    proc_alu #(.WIDTH(WIDTH)) u_alu (
        .op    (op),
        .a     (a),
        .b     (bus),
        .result(alu_res),
        .carry (alu_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            ir    <= '0;
            regs  <= '0;
            a     <= '0;
            g     <= '0;
            z     <= 1'b0;
            c     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ir_load) ir <= io.DIN[WIDTH-1 -: IW];
            if (rx_wr)   regs[rx] <= bus;
            if (a_wr)    a <= bus;
            // Flags move only with G.
            if (g_wr) begin
                g <= alu_res;
                z <= (alu_res == '0);
                c <= alu_c;
            end
        end
    end

    assign io.Done    = done & rst;
    assign io.illegal = bad_op & rst;
    assign io.IRin    = ir_load;
    assign io.busy    = (state != S_IDLE);
    assign io.Z       = z;
    assign io.C       = c;
    assign io.BUS     = bus;
    assign io.A       = a;
    assign io.G       = g;
    assign io.R_flat  = regs;
endmodule

// File: tb/tb_proc_datapath_param.sv
// Directed bench for both parameter sets, checked against an instruction-level model.
module tb_proc_datapath_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    proc_datapath_param_if #(.WIDTH(9),  .NUM_REGS(8))  if9 ();
    proc_datapath_param_if #(.WIDTH(16), .NUM_REGS(16)) if16 ();

    proc_datapath_param #(.WIDTH(9),  .NUM_REGS(8))  dut9  (.clk(clk), .rst(rst), .io(if9));
    proc_datapath_param #(.WIDTH(16), .NUM_REGS(16)) dut16 (.clk(clk), .rst(rst), .io(if16));

    int          dut_sel;
    logic        run_d;
    logic [15:0] din_d;

    assign if9.run  = run_d && (dut_sel == 0);
    assign if9.DIN  = din_d[8:0];
    assign if16.run = run_d && (dut_sel != 0);
    assign if16.DIN = din_d;

    logic        o_done, o_ill, o_busy, o_irin, o_z, o_c;
    logic [15:0] o_a, o_g;
    assign o_done = (dut_sel != 0) ? if16.Done    : if9.Done;
    assign o_ill  = (dut_sel != 0) ? if16.illegal : if9.illegal;
    assign o_busy = (dut_sel != 0) ? if16.busy    : if9.busy;
    assign o_irin = (dut_sel != 0) ? if16.IRin    : if9.IRin;
    assign o_z    = (dut_sel != 0) ? if16.Z       : if9.Z;
    assign o_c    = (dut_sel != 0) ? if16.C       : if9.C;
    assign o_a    = (dut_sel != 0) ? if16.A       : {7'b0, if9.A};
    assign o_g    = (dut_sel != 0) ? if16.G       : {7'b0, if9.G};

    // Instruction-level model of the architectural state.
    int     w, nregs, rwid;
    longint mask;
    longint m_r[16];
    longint m_a, m_g;
    bit     m_z, m_c;

    int cyc = 0;
    int t_run, t_done;
    bit t_ill, chk_en;
    int n_chk, n_fail;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (dut %0d cycle %0d)", nm, act, exp, dut_sel, cyc);
        end
    endtask

    function automatic longint get_r(input int i);
        if (dut_sel != 0) return longint'(if16.R_flat[i*16 +: 16]);
        return longint'(if9.R_flat[i*9 +: 9]);
    endfunction

    function automatic logic [15:0] enc(input int op, input int rx, input int ry);
        longint v;
        v = (longint'(op) << (2*rwid)) | (longint'(rx) << rwid) | longint'(ry);
        v = v << (w - (3 + 2*rwid));
        return 16'(v);
    endfunction

    task automatic set_model(input int width, input int regs);
        w     = width;
        nregs = regs;
        rwid  = $clog2(regs);
        mask  = (longint'(1) << width) - 1;
        for (int i = 0; i < 16; i++) m_r[i] = 0;
        m_a = 0; m_g = 0; m_z = 0; m_c = 0;
        t_run = -100; t_done = -100; t_ill = 0;
    endtask

    // Issue one instruction, wait its architectural latency, then commit the model.
    task automatic issue(input int op, input int rx, input int ry, input longint imm, input bit hold);
        int     lat;
        longint nr[16];
        longint na, ng, va, vb, s;
        bit     nz, nc;
        nr = m_r; na = m_a; ng = m_g; nz = m_z; nc = m_c;
        lat = 2;
        case (op)
            0: nr[rx] = m_r[ry];
            1: nr[rx] = imm & mask;
            6: if (!m_z) nr[rx] = m_r[ry];
            7: ;
            default: begin
                lat = 4;
                va = m_r[rx];
                vb = m_r[ry];
                na = va;
                case (op)
                    2:       s = va + vb;
                    3:       s = va + ((~vb) & mask) + 1;
                    4:       s = va & vb;
                    default: s = va ^ vb;
                endcase
                ng = s & mask;
                nc = ((s >> w) & 1) != 0;
                nz = (ng == 0);
                nr[rx] = ng;
            end
        endcase
        din_d  = enc(op, rx, ry);
        run_d  = 1'b1;
        t_run  = cyc;
        t_done = cyc + lat - 1;
        t_ill  = (op == 7);
        @(posedge clk); #1;
        run_d = hold;
        din_d = 16'(imm);
        repeat (lat - 1) @(posedge clk);
        #1;
        run_d = 1'b0;
        m_r = nr; m_a = na; m_g = ng; m_z = nz; m_c = nc;
    endtask

    always @(negedge clk) begin
        bit bsy;
        if (chk_en) begin
            bsy = (cyc > t_run) && (cyc <= t_done);
            chk("Done",    longint'(o_done), longint'(cyc == t_done));
            chk("illegal", longint'(o_ill),  longint'(cyc == t_done && t_ill));
            chk("busy",    longint'(o_busy), longint'(bsy));
            chk("IRin",    longint'(o_irin), longint'(cyc == t_run));
            if (!bsy) begin
                for (int i = 0; i < nregs; i++) chk($sformatf("R%0d", i), get_r(i), m_r[i]);
                chk("A", longint'(o_a), m_a);
                chk("G", longint'(o_g), m_g);
                chk("Z", longint'(o_z), longint'(m_z));
                chk("C", longint'(o_c), longint'(m_c));
            end
        end
    end

    task automatic suite();
        longint mx;
        mx = (dut_sel != 0) ? 64'hFFFF : 64'h1FF;
        issue(1, 0, 0, 5, 0);             chk("mvi R0", get_r(0), 5);
        issue(1, 1, 0, 3, 0);
        issue(0, 2, 0, 0, 0);             chk("mv R2", get_r(2), 5);
        issue(2, 0, 1, 0, 0);
        chk("add R0", get_r(0), 8);       chk("add G", longint'(o_g), 8);
        chk("add Z", longint'(o_z), 0);   chk("add C", longint'(o_c), 0);
        issue(1, 0, 0, 2, 0);
        issue(3, 0, 1, 0, 0);
        chk("sub wrap R0", get_r(0), mx); chk("sub wrap C", longint'(o_c), 0);
        chk("sub wrap Z", longint'(o_z), 0);
        issue(1, 3, 0, 7, 0);
        issue(3, 1, 1, 0, 0);
        chk("sub0 R1", get_r(1), 0);      chk("sub0 Z", longint'(o_z), 1);
        chk("sub0 C", longint'(o_c), 1);
        issue(6, 3, 0, 0, 0);             chk("mvnz hold R3", get_r(3), 7);
        issue(1, 1, 0, 4, 0);
        issue(2, 1, 1, 0, 0);             chk("add dbl R1", get_r(1), 8);
        issue(6, 3, 0, 0, 0);             chk("mvnz copy R3", get_r(3), mx);
        issue(5, 2, 2, 0, 0);             chk("xor R2", get_r(2), 0);
        chk("xor Z", longint'(o_z), 1);
        // run stays high through the whole ALU instruction and must be ignored.
        issue(4, 3, 0, 16'h0041, 1);      chk("and R3", get_r(3), mx);
        chk("and C", longint'(o_c), 0);
        issue(7, 5, 2, 0, 0);             chk("rsvd R5", get_r(5), 0);
        chk("rsvd Z", longint'(o_z), 0);
        issue(1, nregs - 1, 0, mx, 0);
        issue(1, nregs - 2, 0, 1, 0);
        issue(2, nregs - 1, nregs - 2, 0, 0);
        chk("top wrap R", get_r(nregs - 1), 0);
        chk("top wrap C", longint'(o_c), 1);
        chk("top wrap Z", longint'(o_z), 1);

        // Reset while an add sits in T2.
        chk_en = 1'b0;
        issue(1, 4, 0, 9, 0);
        din_d = enc(2, 0, 1); run_d = 1'b1;
        @(posedge clk); #1; run_d = 1'b0;
        @(posedge clk); #1;
        chk("pre-rst busy", longint'(o_busy), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst Done", longint'(o_done), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < nregs; i++) chk($sformatf("rst R%0d", i), get_r(i), 0);
        chk("rst A", longint'(o_a), 0);   chk("rst G", longint'(o_g), 0);
        chk("rst Z", longint'(o_z), 0);   chk("rst C", longint'(o_c), 0);
        chk("rst busy", longint'(o_busy), 0);
        chk("rst Done2", longint'(o_done), 0);
        set_model(w, nregs);
        chk_en = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; chk_en = 1'b0;
        run_d = 1'b0; din_d = '0; dut_sel = 0;
        set_model(9, 8);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("init busy9",  longint'(if9.busy), 0);
        chk("init R9",     longint'(if9.R_flat != '0), 0);
        chk("init busy16", longint'(if16.busy), 0);
        chk("init R16",    longint'(if16.R_flat != '0), 0);
        chk_en = 1'b1;
        suite();
        @(posedge clk); #1;
        dut_sel = 1;
        set_model(16, 16);
        suite();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
